projection_hist: RTL

PROJECTION_HIST -- requirements
Module: projection_hist

---
 rtl/projection_pkg.sv | 25 ++
 rtl/myram.sv | 24 ++
 rtl/projection_hist_seg_detect.sv | 110 +++++++++++
 rtl/projection_hist.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/projection_pkg.sv
// Shared FSM encoding and border-RAM addressing for the projection histogram.
// Segment k occupies two border words: start at 2k, end at 2k+1.
package projection_pkg;

   typedef enum logic [2:0] {
      ST_CLEAR = 3'd0,
      ST_WAIT  = 3'd1,
      ST_ACCUM = 3'd2,
      ST_SCAN  = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

   function automatic logic [15:0] seg_start_addr(input logic [3:0] k);
      return {11'd0, k, 1'b0};
   endfunction

   function automatic logic [15:0] seg_end_addr(input logic [3:0] k);
      return {11'd0, k, 1'b1};
   endfunction

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/myram.sv
// Simple dual-port RAM: one write port, one synchronous read port (read-first).
module myram #(
   parameter int DW = 8,
   parameter int AW = 4
) (
   input  logic          clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [DW-1:0] i_wdata,
   input  logic [AW-1:0] i_raddr,
   output logic [DW-1:0] o_rdata
);

   logic [DW-1:0] r_mem [0:(1<<AW)-1];

   // A read of the address being written returns the old contents
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
      o_rdata <= r_mem[i_raddr];
   end

endmodule

// File: rtl/projection_hist_seg_detect.sv
// Per-axis segment finder: thresholds a stream of bin counts, filters short runs
// and writes start/end borders of surviving segments into a border RAM.
module seg_detect
   import projection_pkg::*;
#(
   parameter int POS_W   = 11,
   parameter int CNT_W   = 10,
   parameter int MAX_SEG = 8,
   parameter int MIN_W   = 3,
   parameter int AW      = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_start,
   input  logic             i_valid,
   input  logic             i_last,
   input  logic [POS_W-1:0] i_idx,
   input  logic [CNT_W-1:0] i_cnt,
   input  logic [CNT_W-1:0] i_thresh,
   output logic             o_we,
   output logic [AW-1:0]    o_waddr,
   output logic [POS_W-1:0] o_wdata,
   output logic [3:0]       o_count,
   output logic             o_ovf
);

   localparam logic [3:0]   SEG_MAX = 4'(MAX_SEG);
   localparam logic [POS_W:0] MIN_LEN = (POS_W+1)'(MIN_W);

   logic             r_active;
   logic [POS_W-1:0] r_start;
   logic [3:0]       r_count;
   logic             r_ovf;
   logic             r_pend_we;
   logic [AW-1:0]    r_pend_addr;
   logic [POS_W-1:0] r_pend_data;

   logic             w_act, w_open, w_close_fall, w_close_last, w_keep, w_full;
   logic [POS_W-1:0] w_seg_start, w_seg_end;
   logic [POS_W:0]   w_len;

   assign w_act        = (i_cnt >= i_thresh);
   assign w_open       = i_valid & w_act & ~r_active;
   assign w_close_fall = i_valid & ~w_act & r_active;
   assign w_close_last = i_valid & w_act & i_last;
   assign w_seg_start  = w_open ? i_idx : r_start;
   assign w_seg_end    = w_close_fall ? (i_idx - POS_W'(1)) : i_idx;
   assign w_len        = {1'b0, w_seg_end} - {1'b0, w_seg_start} + (POS_W+1)'(1);
   assign w_keep       = (w_close_fall | w_close_last) & (w_len >= MIN_LEN);
   assign w_full       = (r_count == SEG_MAX);
   assign o_count      = r_count;
   assign o_ovf        = r_ovf;

   // Start is written speculatively on open; a dropped segment is overwritten by the next open
   always_comb begin
      o_we    = 1'b0;
      o_waddr = AW'(seg_start_addr(r_count));
      o_wdata = i_idx;
      if (r_pend_we) begin
         o_we    = 1'b1;
         o_waddr = r_pend_addr;
         o_wdata = r_pend_data;
      end else if (w_open && !w_full) begin
         o_we    = 1'b1;
      end else if (w_keep && !w_full) begin
         o_we    = 1'b1;
         o_waddr = AW'(seg_end_addr(r_count));
         o_wdata = w_seg_end;
      end else begin
         o_we    = 1'b0;
      end
   end

   // Run tracking, segment counting and deferred end write for a one-bin last segment
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_active    <= 1'b0;
         r_start     <= '0;
         r_count     <= 4'd0;
         r_ovf       <= 1'b0;
         r_pend_we   <= 1'b0;
         r_pend_addr <= '0;
         r_pend_data <= '0;
      end else if (i_start) begin
         r_active    <= 1'b0;
         r_start     <= '0;
         r_count     <= 4'd0;
         r_ovf       <= 1'b0;
         r_pend_we   <= 1'b0;
      end else begin
         r_pend_we   <= w_open & w_keep & ~w_full;
         r_pend_addr <= AW'(seg_end_addr(r_count));
         r_pend_data <= w_seg_end;
         if (i_valid) begin
            r_active <= w_act;
         end
         if (w_open) begin
            r_start <= i_idx;
         end
         if (w_keep) begin
            if (w_full) begin
               r_ovf <= 1'b1;
            end else begin
               r_count <= r_count + 4'd1;
            end
         end
      end
   end

endmodule

// File: rtl/projection_hist.sv
// Column/row foreground projection histogram with segment extraction per frame.
// Clear bins, accumulate one frame, scan bins into border RAMs, report counts.
module projection_hist
   import projection_pkg::*;
#(
   parameter int H_PIXEL = 1024,
   parameter int V_PIXEL = 768,
   parameter int POS_W   = 11,
   parameter int CNT_W   = 10,
   parameter int MAX_COL = 8,
   parameter int MAX_ROW = 4,
   parameter int MIN_W   = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             frame_vsync,
   input  logic             frame_de,
   input  logic             monoc,
   input  logic             roi_en,
   input  logic [POS_W-1:0] xpos,
   input  logic [POS_W-1:0] ypos,
   input  logic [CNT_W-1:0] col_thresh,
   input  logic [CNT_W-1:0] row_thresh,
   input  logic [POS_W-1:0] col_border_addr_rd,
   output logic [POS_W-1:0] col_border_data_rd,
   input  logic [POS_W-1:0] row_border_addr_rd,
   output logic [POS_W-1:0] row_border_data_rd,
   output logic [3:0]       num_col,
   output logic [3:0]       num_row,
   output logic             project_done,
   output logic             busy,
   output logic             seg_ovf
);

   localparam int BINS   = max_int(H_PIXEL, V_PIXEL);
   localparam int BIN_AW = $clog2(BINS);
   localparam int CBW    = $clog2(2*MAX_COL);
   localparam int RBW    = $clog2(2*MAX_ROW);
   localparam logic [BIN_AW-1:0] LAST_BIN = BIN_AW'(BINS-1);
   localparam logic [BIN_AW:0]   SCAN_END = (BIN_AW+1)'(BINS);
   localparam logic [POS_W:0]    H_LIM    = (POS_W+1)'(H_PIXEL);
   localparam logic [POS_W:0]    V_LIM    = (POS_W+1)'(V_PIXEL);
   localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

   state_e            r_state, w_next;
   logic              r_vs_d, r_de_d, r_flush;
   logic [BIN_AW-1:0] r_clr_addr;
   logic [BIN_AW:0]   r_scan_addr;
   logic              r_sv_valid;
   logic [BIN_AW-1:0] r_sv_idx;
   logic              r_p1_valid, r_fwd_valid;
   logic [BIN_AW-1:0] r_p1_addr, r_fwd_addr;
   logic [CNT_W-1:0]  r_fwd_data, r_line_cnt, r_col_th, r_row_th;
   logic [BIN_AW-1:0] r_line_y;
   logic              r_line_yok;
   logic [3:0]        r_num_col, r_num_row;
   logic              r_done, r_busy, r_seg_ovf;

   logic              w_vs_fall, w_de_fall, w_qual, w_row_wr, w_scan_start;
   logic [CNT_W-1:0]  w_col_q, w_row_q, w_col_src, w_col_inc;
   logic              w_col_we, w_row_we;
   logic [BIN_AW-1:0] w_col_waddr, w_row_waddr, w_col_raddr;
   logic [CNT_W-1:0]  w_col_wdata, w_row_wdata;
   logic              w_col_sv, w_row_sv, w_col_last, w_row_last;
   logic              w_cb_we, w_rb_we, w_col_ovf, w_row_ovf;
   logic [CBW-1:0]    w_cb_waddr;
   logic [RBW-1:0]    w_rb_waddr;
   logic [POS_W-1:0]  w_cb_wdata, w_rb_wdata;
   logic [3:0]        w_col_cnt, w_row_cnt;

   assign w_vs_fall    = r_vs_d & ~frame_vsync;
   assign w_de_fall    = r_de_d & ~frame_de;
   assign w_qual       = (r_state == ST_ACCUM) & ~r_flush & frame_de & ~monoc & roi_en &
                         ({1'b0, xpos} < H_LIM) & ({1'b0, ypos} < V_LIM);
   assign w_row_wr     = (r_state == ST_ACCUM) & w_de_fall & r_line_yok;
   assign w_scan_start = (r_state == ST_ACCUM) & (w_next == ST_SCAN);
   // Forward the previous write so back-to-back hits on one bin do not lose counts
   assign w_col_src    = (r_fwd_valid && (r_fwd_addr == r_p1_addr)) ? r_fwd_data : w_col_q;
   assign w_col_inc    = (w_col_src == CNT_MAX) ? CNT_MAX : (w_col_src + CNT_W'(1));
   assign w_col_sv     = r_sv_valid & ((POS_W+1)'(r_sv_idx) < H_LIM);
   assign w_row_sv     = r_sv_valid & ((POS_W+1)'(r_sv_idx) < V_LIM);
   assign w_col_last   = ((POS_W+1)'(r_sv_idx) == (H_LIM - (POS_W+1)'(1)));
   assign w_row_last   = ((POS_W+1)'(r_sv_idx) == (V_LIM - (POS_W+1)'(1)));

   assign num_col      = r_num_col;
   assign num_row      = r_num_row;
   assign project_done = r_done;
   assign busy         = r_busy;
   assign seg_ovf      = r_seg_ovf;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_CLEAR;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic; leaving accumulate waits for the column pipeline to drain
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_CLEAR: if (r_clr_addr == LAST_BIN) w_next = ST_WAIT; else w_next = ST_CLEAR;
         ST_WAIT:  if (w_vs_fall) w_next = ST_ACCUM; else w_next = ST_WAIT;
         ST_ACCUM: if (r_flush && !r_p1_valid) w_next = ST_SCAN; else w_next = ST_ACCUM;
         ST_SCAN:  if ((r_scan_addr == SCAN_END) && !r_sv_valid) w_next = ST_DONE;
                   else w_next = ST_SCAN;
         ST_DONE:  w_next = ST_CLEAR;
         default:  w_next = ST_CLEAR;
      endcase
   end

   // Bin RAM port steering: clear writes zeros, accumulate does read-modify-write
   always_comb begin
      w_col_raddr = (r_state == ST_SCAN) ? r_scan_addr[BIN_AW-1:0] : BIN_AW'(xpos);
      w_col_we    = 1'b0;
      w_col_waddr = r_p1_addr;
      w_col_wdata = w_col_inc;
      w_row_we    = 1'b0;
      w_row_waddr = r_line_y;
      w_row_wdata = r_line_cnt;
      if (r_state == ST_CLEAR) begin
         w_col_we    = 1'b1;
         w_col_waddr = r_clr_addr;
         w_col_wdata = '0;
         w_row_we    = 1'b1;
         w_row_waddr = r_clr_addr;
         w_row_wdata = '0;
      end else begin
         w_col_we = r_p1_valid;
         w_row_we = w_row_wr;
      end
   end

   // Datapath: clear/scan counters, accumulate pipeline, line counter, result latches
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vs_d      <= 1'b0;
         r_de_d      <= 1'b0;
         r_flush     <= 1'b0;
         r_clr_addr  <= '0;
         r_scan_addr <= '0;
         r_sv_valid  <= 1'b0;
         r_sv_idx    <= '0;
         r_p1_valid  <= 1'b0;
         r_p1_addr   <= '0;
         r_fwd_valid <= 1'b0;
         r_fwd_addr  <= '0;
         r_fwd_data  <= '0;
         r_line_cnt  <= '0;
         r_line_y    <= '0;
         r_line_yok  <= 1'b0;
         r_col_th    <= '0;
         r_row_th    <= '0;
         r_num_col   <= 4'd0;
         r_num_row   <= 4'd0;
         r_done      <= 1'b0;
         r_busy      <= 1'b1;
         r_seg_ovf   <= 1'b0;
      end else begin
         r_vs_d      <= frame_vsync;
         r_de_d      <= frame_de;
         r_flush     <= (r_state == ST_ACCUM) & (r_flush | w_vs_fall);
         r_clr_addr  <= (r_state == ST_CLEAR) ? (r_clr_addr + BIN_AW'(1)) : '0;
         r_p1_valid  <= w_qual;
         r_p1_addr   <= BIN_AW'(xpos);
         r_fwd_valid <= r_p1_valid;
         r_fwd_addr  <= r_p1_addr;
         r_fwd_data  <= w_col_inc;
         if (r_state != ST_ACCUM) begin
            r_line_cnt <= '0;
            r_line_yok <= 1'b0;
         end else if (w_de_fall) begin
            r_line_cnt <= '0;
         end else if (w_qual && (r_line_cnt != CNT_MAX)) begin
            r_line_cnt <= r_line_cnt + CNT_W'(1);
         end
         if ((r_state == ST_ACCUM) && frame_de) begin
            r_line_y   <= BIN_AW'(ypos);
            r_line_yok <= ({1'b0, ypos} < V_LIM);
         end
         if (w_scan_start) begin
            r_scan_addr <= '0;
            r_col_th    <= col_thresh;
            r_row_th    <= row_thresh;
         end else if ((r_state == ST_SCAN) && (r_scan_addr != SCAN_END)) begin
            r_scan_addr <= r_scan_addr + (BIN_AW+1)'(1);
         end
         r_sv_valid <= (r_state == ST_SCAN) && (r_scan_addr != SCAN_END);
         r_sv_idx   <= r_scan_addr[BIN_AW-1:0];
         r_done     <= (w_next == ST_DONE);
         r_busy     <= (w_next != ST_WAIT);
         if (w_scan_start) begin
            r_seg_ovf <= 1'b0;
         end else if (w_next == ST_DONE) begin
            r_num_col <= w_col_cnt;
            r_num_row <= w_row_cnt;
            r_seg_ovf <= w_col_ovf | w_row_ovf;
         end
      end
   end

   myram #(.DW(CNT_W), .AW(BIN_AW)) u_col_bins (
      .clk(clk), .i_we(w_col_we), .i_waddr(w_col_waddr), .i_wdata(w_col_wdata),
      .i_raddr(w_col_raddr), .o_rdata(w_col_q));

   myram #(.DW(CNT_W), .AW(BIN_AW)) u_row_bins (
      .clk(clk), .i_we(w_row_we), .i_waddr(w_row_waddr), .i_wdata(w_row_wdata),
      .i_raddr(r_scan_addr[BIN_AW-1:0]), .o_rdata(w_row_q));

   seg_detect #(.POS_W(POS_W), .CNT_W(CNT_W), .MAX_SEG(MAX_COL), .MIN_W(MIN_W), .AW(CBW)) u_col_seg (
      .clk(clk), .rst_n(rst_n), .i_start(w_scan_start), .i_valid(w_col_sv), .i_last(w_col_last),
      .i_idx(POS_W'(r_sv_idx)), .i_cnt(w_col_q), .i_thresh(r_col_th),
      .o_we(w_cb_we), .o_waddr(w_cb_waddr), .o_wdata(w_cb_wdata),
      .o_count(w_col_cnt), .o_ovf(w_col_ovf));

   seg_detect #(.POS_W(POS_W), .CNT_W(CNT_W), .MAX_SEG(MAX_ROW), .MIN_W(MIN_W), .AW(RBW)) u_row_seg (
      .clk(clk), .rst_n(rst_n), .i_start(w_scan_start), .i_valid(w_row_sv), .i_last(w_row_last),
      .i_idx(POS_W'(r_sv_idx)), .i_cnt(w_row_q), .i_thresh(r_row_th),
      .o_we(w_rb_we), .o_waddr(w_rb_waddr), .o_wdata(w_rb_wdata),
      .o_count(w_row_cnt), .o_ovf(w_row_ovf));

   myram #(.DW(POS_W), .AW(CBW)) u_col_border (
      .clk(clk), .i_we(w_cb_we), .i_waddr(w_cb_waddr), .i_wdata(w_cb_wdata),
      .i_raddr(CBW'(col_border_addr_rd)), .o_rdata(col_border_data_rd));

   myram #(.DW(POS_W), .AW(RBW)) u_row_border (
      .clk(clk), .i_we(w_rb_we), .i_waddr(w_rb_waddr), .i_wdata(w_rb_wdata),
      .i_raddr(RBW'(row_border_addr_rd)), .o_rdata(row_border_data_rd));

endmodule
